// File: rtl/acc_display_pkg.sv
// Shared seven-segment display constants: active-low segment patterns {g,f,e,d,c,b,a}
// and anode helpers, reusable by any display block in the codebase.
package acc_display_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_DARK = 7'b1111111;

    localparam logic [3:0] AN_DARK = 4'b1111;
    localparam logic       DP_OFF  = 1'b1;

    // One-hot-low anode pattern lighting digit idx (digit 0 is rightmost).
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/acc_display_hex_to_7seg.sv
// Purely combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
    import acc_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DARK;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
            default: pattern = SEG_DARK;
        endcase
    end

endmodule

// File: rtl/acc_display.sv
// Four-digit multiplexed hex display of the accumulator, with a frame-coherent
// snapshot, optional leading-zero suppression and a blanking input.
module acc_display
    import acc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit LZ_BLANK    = 1'b0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [15:0] LAST_COUNT = 16'(REFRESH_DIV - 1);

    logic [15:0] count;
    logic [1:0]  idx;
    logic [15:0] snapshot;

    logic        tick;
    logic [15:0] count_next;
    logic [1:0]  idx_next;
    logic [15:0] snapshot_next;
    logic [3:0]  nibble_next;
    logic [6:0]  seg_next;
    logic        lead_zero;
    logic [3:0]  an_next;

    assign tick = (count == LAST_COUNT);

    // Outputs are computed from the post-edge index and snapshot, so on the
    // frame wrap digit 0 already shows the freshly sampled value[3:0].
    always_comb begin
        count_next    = tick ? 16'd0 : count + 16'd1;
        idx_next      = tick ? idx + 2'd1 : idx;
        snapshot_next = (tick && idx == 2'd3) ? value : snapshot;
        nibble_next   = snapshot_next[{idx_next, 2'b00} +: 4];
    end

    always_comb begin
        lead_zero = 1'b0;
        case (idx_next)
            2'd1:    lead_zero = (snapshot_next[15:4]  == 12'h000);
            2'd2:    lead_zero = (snapshot_next[15:8]  == 8'h00);
            2'd3:    lead_zero = (snapshot_next[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end

    assign an_next = (blank || (LZ_BLANK && lead_zero)) ? AN_DARK : an_select(idx_next);

    hex_to_7seg u_decode (
        .nibble  (nibble_next),
        .pattern (seg_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 16'd0;
            idx      <= 2'd0;
            snapshot <= 16'h0000;
            an       <= an_select(2'd0);
            seg      <= SEG_0;
            dp       <= DP_OFF;
        end else begin
            count    <= count_next;
            idx      <= idx_next;
            snapshot <= snapshot_next;
            an       <= an_next;
            seg      <= seg_next;
            dp       <= DP_OFF;
        end
    end

endmodule

// File: tb/tb_acc_display.sv
// Self-checking bench for acc_display: an edge-counting reference model checks two
// instances (plain and leading-zero-blanked) every cycle, plus literal spot checks.
module tb_acc_display;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        blank;
    logic [3:0]  an, an_lz;
    logic [6:0]  seg, seg_lz;
    logic        dp, dp_lz;

    int checks = 0;
    int errors = 0;

    acc_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .reset(reset), .value(value), .blank(blank),
        .an(an), .seg(seg), .dp(dp)
    );

    acc_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .reset(reset), .value(value), .blank(blank),
        .an(an_lz), .seg(seg_lz), .dp(dp_lz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: n counts edges since the last reset edge; the digit is (n/DIV)%4 and
    // each frame starting at n = k*FRAME shows value as sampled on that edge.
    int          n = 0;
    bit          model_valid = 1'b0;
    logic [15:0] model_snap = 16'h0000;
    logic [3:0]  exp_an, exp_an_lz;
    logic [6:0]  exp_seg;

    always @(posedge clk) begin
        int digit;
        logic [15:0] upper;
        if (reset) begin
            n = 0;
            model_snap = 16'h0000;
            model_valid = 1'b1;
        end else if (model_valid) begin
            n = n + 1;
            if (n % FRAME == 0) model_snap = value;
        end
        digit   = (n / DIV) % 4;
        upper   = model_snap >> (4 * digit);
        exp_seg = seg_table[upper[3:0]];
        if (!reset && blank) begin
            exp_an    = 4'b1111;
            exp_an_lz = 4'b1111;
        end else begin
            exp_an    = ~(4'b0001 << digit);
            exp_an_lz = (digit > 0 && upper == 16'h0000) ? 4'b1111 : exp_an;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
                errors++;
                $display("[TB] FAIL model_plain n=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                         n, an, seg, dp, exp_an, exp_seg);
            end
            checks++;
            if (an_lz !== exp_an_lz || seg_lz !== exp_seg || dp_lz !== 1'b1) begin
                errors++;
                $display("[TB] FAIL model_lz n=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                         n, an_lz, seg_lz, dp_lz, exp_an_lz, exp_seg);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] v, input logic b, input logic r);
        value = v;
        blank = b;
        reset = r;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] got_an, input logic [6:0] got_seg,
                               input logic got_dp, input logic [3:0] want_an, input logic [6:0] want_seg);
        checks++;
        if (got_an !== want_an || got_seg !== want_seg || got_dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                     name, got_an, got_seg, got_dp, want_an, want_seg);
        end
    endtask

    task automatic waitEdges(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just after the final reset edge (n = 0).
    task automatic doReset(input logic [15:0] v);
        applyStimulus(v, 1'b0, 1'b1);
        waitEdges(2);
        reset = 1'b0;
    endtask

    initial begin
        applyStimulus(16'h0000, 1'b0, 1'b0);
        waitEdges(1);

        doReset(16'h0000);
        checkOutput("reset_state", an, seg, dp, 4'b1110, 7'b1000000);
        waitEdges(3);
        checkOutput("slot0_end", an, seg, dp, 4'b1110, 7'b1000000);
        waitEdges(1);
        checkOutput("slot1_start", an, seg, dp, 4'b1101, 7'b1000000);

        doReset(16'h1234);
        waitEdges(16);
        checkOutput("v1234_d0", an, seg, dp, 4'b1110, 7'b0011001);
        waitEdges(4);
        checkOutput("v1234_d1", an, seg, dp, 4'b1101, 7'b0110000);
        waitEdges(4);
        checkOutput("v1234_d2", an, seg, dp, 4'b1011, 7'b0100100);
        waitEdges(4);
        checkOutput("v1234_d3", an, seg, dp, 4'b0111, 7'b1111001);

        waitEdges(12);
        checkOutput("tear_d2", an, seg, dp, 4'b1011, 7'b0100100);
        value = 16'hABCD;
        waitEdges(4);
        checkOutput("tear_d3", an, seg, dp, 4'b0111, 7'b1111001);
        waitEdges(4);
        checkOutput("abcd_d0", an, seg, dp, 4'b1110, 7'b0100001);
        waitEdges(4);
        checkOutput("abcd_d1", an, seg, dp, 4'b1101, 7'b1000110);
        waitEdges(4);
        checkOutput("abcd_d2", an, seg, dp, 4'b1011, 7'b0000011);
        waitEdges(4);
        checkOutput("abcd_d3", an, seg, dp, 4'b0111, 7'b0001000);

        waitEdges(9);
        blank = 1'b1;
        waitEdges(1);
        checkOutput("blank_on", an, seg, dp, 4'b1111, 7'b1000110);
        waitEdges(5);
        blank = 1'b0;
        waitEdges(1);
        checkOutput("blank_off", an, seg, dp, 4'b0111, 7'b0001000);

        value = 16'hFFFF;
        waitEdges(13);
        reset = 1'b1;
        waitEdges(1);
        reset = 1'b0;
        checkOutput("mid_reset", an, seg, dp, 4'b1110, 7'b1000000);
        waitEdges(16);
        checkOutput("ffff_d0", an, seg, dp, 4'b1110, 7'b0001110);
        waitEdges(12);
        checkOutput("ffff_d3", an, seg, dp, 4'b0111, 7'b0001110);

        doReset(16'h0042);
        waitEdges(16);
        checkOutput("lz_d0", an_lz, seg_lz, dp_lz, 4'b1110, 7'b0100100);
        waitEdges(4);
        checkOutput("lz_d1", an_lz, seg_lz, dp_lz, 4'b1101, 7'b0011001);
        waitEdges(4);
        checkOutput("lz_d2_dark", an_lz, seg_lz, dp_lz, 4'b1111, 7'b1000000);
        waitEdges(4);
        checkOutput("lz_d3_dark", an_lz, seg_lz, dp_lz, 4'b1111, 7'b1000000);
        value = 16'h0000;
        waitEdges(4);
        checkOutput("lz_zero_d0", an_lz, seg_lz, dp_lz, 4'b1110, 7'b1000000);
        waitEdges(4);
        checkOutput("lz_zero_d1", an_lz, seg_lz, dp_lz, 4'b1111, 7'b1000000);

        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            logic        b;
            v = value;
            b = blank;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0:       v = 16'($urandom_range(0, 15));
                    1:       v = 16'($urandom_range(0, 255));
                    default: v = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 24) == 0) b = ~b;
            applyStimulus(v, b, ($urandom_range(0, 199) == 0));
            waitEdges(1);
        end

        applyStimulus(16'h0000, 1'b0, 1'b0);
        waitEdges(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
